// File: rtl/pn_soma_driver_if.sv
// Config and event handshake bundle between an upstream controller and pn_soma_driver.
// Both channels transfer on a rising clock edge where valid and ready are both high.
interface pn_soma_driver_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_interval;
    logic [15:0] ev_weight;

    modport master (
        output cfg_valid, cfg_data, ev_valid, ev_interval, ev_weight,
        input  cfg_ready, ev_ready
    );

    modport slave (
        input  cfg_valid, cfg_data, ev_valid, ev_interval, ev_weight,
        output cfg_ready, ev_ready
    );
endinterface

// File: rtl/pn_soma_driver.sv
// Soma driver: loads a config word, queues spike events in a FIFO and issues them to the
// soma one per cycle, tracking absolute time and reporting soma fire times.
module pn_soma_driver #(
    parameter int DEPTH    = 4,
    parameter int CFG_HOLD = 2
) (
    input  logic                clk,
    input  logic                rst,
    pn_soma_driver_if.slave     bus,
    input  logic                stop_req,
    input  logic                kill_req,
    input  logic                soma_wait,
    input  logic [15:0]         soma_spike,
    output logic                en,
    output logic                kill,
    output logic [31:0]         W_DATA,
    output logic [15:0]         weight,
    output logic                fire_valid,
    output logic [15:0]         fire_time,
    output logic                busy,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_KILL   = 3'd4
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;

    state_t          state, state_nx;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [15:0]     mem_int [DEPTH];
    logic [15:0]     mem_wt  [DEPTH];
    logic [HW-1:0]   hold_cnt;
    logic [15:0]     t_now;
    logic [16:0]     fire_sum;

    logic fifo_full, fifo_empty, active;
    logic cfg_ready_c, ev_ready_c;
    logic load_cfg, issue, flush, set_en, clr_en, push, fire_hit;

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign push       = bus.ev_valid && ev_ready_c;
    assign fire_sum   = {1'b0, t_now} + {1'b0, soma_spike};
    assign fire_hit   = active && !kill_req && (soma_spike != 16'h0000);

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.ev_ready  = ev_ready_c;
    assign busy          = (state != S_IDLE);
    assign dbg_state     = state;

    // kill_req overrides every other decision, including both handshakes.
    always_comb begin
        state_nx    = state;
        cfg_ready_c = 1'b0;
        ev_ready_c  = 1'b0;
        load_cfg    = 1'b0;
        issue       = 1'b0;
        flush       = 1'b0;
        set_en      = 1'b0;
        clr_en      = 1'b0;
        if (kill_req) begin
            state_nx = S_KILL;
            flush    = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cfg_ready_c = 1'b1;
                    if (bus.cfg_valid) begin
                        load_cfg = 1'b1;
                        state_nx = S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    if (hold_cnt == HW'(CFG_HOLD - 1)) begin
                        set_en   = 1'b1;
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    ev_ready_c = !fifo_full;
                    issue      = !fifo_empty && !soma_wait;
                    if (stop_req) state_nx = S_DRAIN;
                end
                S_DRAIN: begin
                    issue = !fifo_empty && !soma_wait;
                    if (fifo_empty) begin
                        clr_en   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_KILL:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            en         <= 1'b0;
            kill       <= 1'b0;
            W_DATA     <= 32'h0;
            weight     <= 16'h0;
            fire_valid <= 1'b0;
            fire_time  <= 16'h0;
            hold_cnt   <= '0;
            t_now      <= 16'h0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_nx;
            kill  <= flush;

            if (load_cfg)
                hold_cnt <= '0;
            else if (state == S_CONFIG)
                hold_cnt <= hold_cnt + HW'(1);

            if (load_cfg)
                W_DATA <= bus.cfg_data;
            else if (issue)
                W_DATA <= {16'h0000, mem_int[rd_ptr]};

            // Weight holds under back-pressure, otherwise it is a one-cycle pulse per issue.
            if (issue)
                weight <= mem_wt[rd_ptr];
            else if (flush || clr_en || !soma_wait)
                weight <= 16'h0;

            if (flush || clr_en)
                en <= 1'b0;
            else if (set_en)
                en <= 1'b1;

            if (flush)
                t_now <= 16'h0;
            else if (issue)
                t_now <= t_now + mem_int[rd_ptr];

            fire_valid <= fire_hit;
            if (fire_hit)
                fire_time <= fire_sum[16] ? 16'hFFFF : fire_sum[15:0];

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)  wr_ptr <= wr_ptr + AW'(1);
                if (issue) rd_ptr <= rd_ptr + AW'(1);
                if (push && !issue)
                    count <= count + (AW+1)'(1);
                else if (issue && !push)
                    count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_int[wr_ptr] <= bus.ev_interval;
            mem_wt[wr_ptr]  <= bus.ev_weight;
        end
    end

endmodule

// File: tb/tb_pn_soma_driver.sv
// Self-checking bench for pn_soma_driver: scoreboard of issued events and fire reports.
module tb_pn_soma_driver;
  logic        clk;
  logic        rst;
  logic        stop_req, kill_req, soma_wait;
  logic [15:0] soma_spike;
  logic        en, kill, fire_valid, busy;
  logic [31:0] W_DATA;
  logic [15:0] weight, fire_time;
  logic [2:0]  dbg_state;

  pn_soma_driver_if bus();

  pn_soma_driver #(.DEPTH(4), .CFG_HOLD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stop_req   (stop_req),
    .kill_req   (kill_req),
    .soma_wait  (soma_wait),
    .soma_spike (soma_spike),
    .en         (en),
    .kill       (kill),
    .W_DATA     (W_DATA),
    .weight     (weight),
    .fire_valid (fire_valid),
    .fire_time  (fire_time),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_issued = 0;
  logic [31:0] exp_q[$];
  logic [15:0] fire_q[$];
  logic [15:0] t_model = 16'h0;
  logic        wait_q = 1'b0;
  logic [31:0] mon_e;
  logic [15:0] mon_f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: an issue is a nonzero weight after an edge with soma_wait low
  always @(posedge clk) wait_q <= soma_wait;

  always @(negedge clk) begin
    if (rst && weight != 16'h0 && !wait_q) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_issue", {16'h0, weight}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("issue_wdata", W_DATA, {16'h0, mon_e[31:16]});
        check_eq("issue_weight", {16'h0, weight}, {16'h0, mon_e[15:0]});
        t_model = t_model + mon_e[31:16];
        n_issued++;
      end
    end
    if (rst && fire_valid) begin
      if (fire_q.size() == 0) begin
        check_eq("spurious_fire", {31'h0, fire_valid}, 32'h0);
      end else begin
        mon_f = fire_q.pop_front();
        check_eq("fire_time", {16'h0, fire_time}, {16'h0, mon_f});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_en", {31'h0, en}, 32'h0);
    check_eq("rst_kill", {31'h0, kill}, 32'h0);
    check_eq("rst_wdata", W_DATA, 32'h0);
    check_eq("rst_weight", {16'h0, weight}, 32'h0);
    check_eq("rst_fire_valid", {31'h0, fire_valid}, 32'h0);
    check_eq("rst_fire_time", {16'h0, fire_time}, 32'h0);
    check_eq("rst_ev_ready", {31'h0, bus.ev_ready}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_state", {29'h0, dbg_state}, 32'h0);
  endtask

  task automatic do_config(input logic [31:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    @(negedge clk);
    check_eq("cfg_ready", {31'h0, bus.cfg_ready}, 32'h1);
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check_eq("cfg_wdata_c1", W_DATA, d);
    check_eq("cfg_en_c1", {31'h0, en}, 32'h0);
    check_eq("cfg_busy", {31'h0, busy}, 32'h1);
    check_eq("cfg_state", {29'h0, dbg_state}, 32'h1);
    @(negedge clk);
    check_eq("cfg_wdata_c2", W_DATA, d);
    check_eq("cfg_en_c2", {31'h0, en}, 32'h0);
    @(negedge clk);
    check_eq("cfg_en_on", {31'h0, en}, 32'h1);
    check_eq("cfg_run", {29'h0, dbg_state}, 32'h2);
    tick();
  endtask

  task automatic push_ev(input logic [15:0] iv, input logic [15:0] w);
    int n;
    n = 0;
    bus.ev_valid    = 1'b1;
    bus.ev_interval = iv;
    bus.ev_weight   = w;
    @(negedge clk);
    while (!bus.ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", {31'h0, bus.ev_ready}, 32'h1);
    if (bus.ev_ready) exp_q.push_back({iv, w});
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", exp_q.size(), 32'h0);
    tick();
  endtask

  task automatic spike(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, t_model} + {1'b0, v};
    fire_q.push_back(s[16] ? 16'hFFFF : s[15:0]);
    soma_spike = v;
    tick();
    soma_spike = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check_eq("fire_consumed", fire_q.size(), 32'h0);
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (dbg_state != s && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {29'h0, dbg_state}, {29'h0, s});
  endtask

  logic [31:0] w_hold;
  logic [15:0] wt_hold;

  initial begin
    rst = 1'b0;
    stop_req = 1'b0; kill_req = 1'b0; soma_wait = 1'b0; soma_spike = 16'h0;
    bus.cfg_valid = 1'b0; bus.cfg_data = 32'h0;
    bus.ev_valid = 1'b0; bus.ev_interval = 16'h0; bus.ev_weight = 16'h0;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("idle_cfg_ready", {31'h0, bus.cfg_ready}, 32'h1);
    check_eq("idle_busy", {31'h0, busy}, 32'h0);
    tick();

    // config hold and enable
    do_config(32'h40020503);

    // three back-to-back events
    push_ev(16'd10, 16'd5);
    push_ev(16'd20, 16'd6);
    push_ev(16'd30, 16'd7);
    bus.ev_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    check_eq("post_issue_weight", {16'h0, weight}, 32'h0);
    check_eq("post_issue_wdata", W_DATA, 32'h0000001E);
    check_eq("issued_3", n_issued, 32'd3);
    tick();
    spike(16'h0001);
    spike(16'h0100);

    // back-pressure fills the FIFO
    soma_wait = 1'b1;
    for (int i = 0; i < 4; i++) push_ev(16'(100 + i), 16'(1 + i));
    bus.ev_valid = 1'b0;
    @(negedge clk);
    check_eq("full_ev_ready", {31'h0, bus.ev_ready}, 32'h0);
    w_hold  = W_DATA;
    wt_hold = weight;
    repeat (3) @(negedge clk);
    check_eq("wait_wdata_hold", W_DATA, w_hold);
    check_eq("wait_weight_hold", {16'h0, weight}, {16'h0, wt_hold});
    tick();
    soma_wait = 1'b0;
    wait_drain();
    @(negedge clk);
    check_eq("ready_again", {31'h0, bus.ev_ready}, 32'h1);
    check_eq("issued_7", n_issued, 32'd7);
    tick();

    // zero interval, then timestamp wrap and fire saturation
    push_ev(16'd0, 16'd9);
    bus.ev_valid = 1'b0;
    wait_drain();
    push_ev(16'hFFF0 - t_model, 16'd3);
    bus.ev_valid = 1'b0;
    wait_drain();
    spike(16'h0020);

    // graceful stop with 3 queued
    soma_wait = 1'b1;
    push_ev(16'd5, 16'd2);
    push_ev(16'd6, 16'd3);
    push_ev(16'd7, 16'd4);
    bus.ev_valid = 1'b0;
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    bus.ev_valid = 1'b1; bus.ev_interval = 16'd99; bus.ev_weight = 16'd99;
    @(negedge clk);
    check_eq("drain_state", {29'h0, dbg_state}, 32'h3);
    check_eq("drain_ev_ready", {31'h0, bus.ev_ready}, 32'h0);
    tick();
    soma_wait = 1'b0;
    wait_state(3'd0, "stop_to_idle");
    check_eq("stop_en", {31'h0, en}, 32'h0);
    check_eq("stop_weight", {16'h0, weight}, 32'h0);
    check_eq("stop_queue", exp_q.size(), 32'h0);
    tick();
    bus.ev_valid = 1'b0;

    // kill with 2 queued and cfg_valid high
    do_config(32'h11223344);
    soma_wait = 1'b1;
    push_ev(16'd40, 16'd1);
    push_ev(16'd41, 16'd2);
    bus.ev_valid  = 1'b1;
    bus.cfg_valid = 1'b1;
    kill_req = 1'b1;
    @(negedge clk);
    check_eq("kill_no_ev_ready", {31'h0, bus.ev_ready}, 32'h0);
    check_eq("kill_no_cfg_ready", {31'h0, bus.cfg_ready}, 32'h0);
    tick();
    kill_req = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.ev_valid  = 1'b0;
    exp_q.delete();
    t_model = 16'h0;
    @(negedge clk);
    check_eq("kill_pulse", {31'h0, kill}, 32'h1);
    check_eq("kill_en", {31'h0, en}, 32'h0);
    check_eq("kill_state", {29'h0, dbg_state}, 32'h4);
    check_eq("kill_weight", {16'h0, weight}, 32'h0);
    @(negedge clk);
    check_eq("kill_release", {31'h0, kill}, 32'h0);
    check_eq("kill_idle", {29'h0, dbg_state}, 32'h0);
    check_eq("kill_cfg_ready", {31'h0, bus.cfg_ready}, 32'h1);
    tick();
    soma_wait = 1'b0;
    repeat (4) tick();
    do_config(32'hA5A50000);
    repeat (4) tick();
    spike(16'h0005);

    // reset mid-RUN discards queued events
    soma_wait = 1'b1;
    push_ev(16'd7, 16'd7);
    push_ev(16'd8, 16'd8);
    bus.ev_valid = 1'b0;
    #2 rst = 1'b0;
    exp_q.delete();
    t_model = 16'h0;
    #1;
    check_reset_outputs();
    tick();
    rst = 1'b1;
    soma_wait = 1'b0;
    do_config(32'h00000001);
    repeat (4) tick();
    push_ev(16'd8, 16'd8);
    bus.ev_valid = 1'b0;
    wait_drain();
    spike(16'h0002);

    check_eq("final_exp_q", exp_q.size(), 32'h0);
    check_eq("final_fire_q", fire_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pn_soma_driver.md
PN_SOMA_DRIVER -- requirements
Module: pn_soma_driver

Interface
REQ-001 Parameters: DEPTH, default 4, event FIFO depth (power of 2, min 2); CFG_HOLD, default 2, cycles cfg word held on W_DATA before en asserts (min 1).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cfg_valid / cfg_ready  in/out  1/1  config handshake; transfer when both high on a clock edge.
REQ-005 cfg_data  in  32  {V_th[31:24], V_leak[23:16], refr_time[15:8], axon_delay[7:0]}.
REQ-006 ev_valid / ev_ready  in/out  1/1  event handshake; transfer when both high.
REQ-007 ev_interval  in  16  inter-spike interval of the event.
REQ-008 ev_weight  in  16  synaptic weight of the event.
REQ-009 stop_req  in  1  graceful stop: drain FIFO, then deactivate soma.
REQ-010 kill_req  in  1  immediate abort.
REQ-011 soma_wait  in  1  soma back-pressure; high = do not issue.
REQ-012 soma_spike  in  16  soma spike output; nonzero = fire, value = relative spike time.
REQ-013 en / kill  out  1/1  soma enable / soma kill, registered.
REQ-014 W_DATA  out  32  word to soma, registered.
REQ-015 weight  out  16  weight to soma, registered.
REQ-016 fire_valid / fire_time  out  1/16  one-cycle absolute fire report.
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states: IDLE, CONFIG, RUN, DRAIN, KILL.
REQ-019 IDLE: cfg_ready=1, ev_ready=0; on cfg transfer, W_DATA<=cfg_data, hold counter<=0, go CONFIG.
REQ-020 CONFIG: cfg_ready=0; W_DATA held; after CFG_HOLD cycles in CONFIG, en<=1 and go RUN.
REQ-021 RUN: ev_ready = !fifo_full (registered flag, no full-cycle bypass); cfg_ready=0.
REQ-022 Issue: in RUN/DRAIN, when FIFO non-empty and soma_wait=0, pop head; next edge W_DATA<={16'h0000, interval}, weight<=ev weight; one issue per cycle max.
REQ-023 soma_wait=1: no pop; W_DATA and weight hold current values.
REQ-024 No issue and soma_wait=0: weight<=0; W_DATA holds.
REQ-025 Push and pop in same cycle legal when not full; occupancy unchanged.
REQ-026 Timestamp t_now (16-bit) += interval on each issue, wrapping modulo 2^16.
REQ-027 Fire: in RUN/DRAIN, soma_spike!=0 -> next edge fire_valid=1, fire_time=t_now+soma_spike, saturated to 16'hFFFF on 17-bit overflow; else fire_valid=0.
REQ-028 stop_req in RUN -> DRAIN: ev_ready=0; issue continues; when FIFO empty and no issue pending, en<=0, weight<=0, go IDLE.
REQ-029 stop_req ignored outside RUN; in CONFIG it is not latched.
REQ-030 kill_req in any state (priority over all same-cycle events, incl. handshakes) -> KILL: kill=1, en=0, weight=0, FIFO flushed, t_now=0, no transfer accepted.
REQ-031 KILL lasts exactly one cycle, then IDLE with kill=0; kill_req still high re-enters KILL.
REQ-032 Events with ev_interval=0 accepted and issued unchanged.

Reset
REQ-033 rst low (async): state IDLE, en=0, kill=0, W_DATA=0, weight=0, fire_valid=0, fire_time=0, cfg_ready=1 after release, ev_ready=0, busy=0, FIFO empty, t_now=0; reset mid-RUN discards all queued events.

Verification
REQ-034 cfg_data=32'h40_02_05_03 accepted -> W_DATA=32'h40020503 for 2 cycles, en=1 on the following edge, busy=1.
REQ-035 RUN, push intervals 10,20,30 weights 5,6,7, soma_wait=0 -> W_DATA 0x000A,0x0014,0x001E with weights 5,6,7 on consecutive cycles, then weight=0; t_now=60.
REQ-036 Push 4 events with soma_wait=1 -> ev_ready=0 after 4th; W_DATA/weight stable; soma_wait released -> 4 issues in order, ev_ready=1 again.
REQ-037 t_now=16'hFFF0, soma_spike=16'h0020 -> fire_valid=1 one cycle, fire_time=16'hFFFF.
REQ-038 3 queued, stop_req -> 3 issues, then en=0, state IDLE; ev_valid during DRAIN not accepted.
REQ-039 kill_req with 2 queued and cfg_valid high -> kill=1 one cycle, en=0, FIFO empty, then IDLE, cfg_ready=1; rst low mid-RUN -> all outputs at REQ-033 values immediately.
